// File: rtl/cordic_phase_sequencer.sv
// cordic_phase_sequencer: phase accumulator, quadrant fold and result unfold around an iterative CORDIC
module cordic_phase_sequencer #(
    parameter int N_FRAC   = 7,
    parameter int BW_PHASE = 16,
    parameter int X_INIT   = 77
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic [BW_PHASE-1:0] phase_inc_i,
    input  logic                sample_strobe_i,
    output logic [N_FRAC:0]     cordic_x_o,
    output logic [N_FRAC:0]     cordic_y_o,
    output logic [N_FRAC:0]     cordic_z_o,
    output logic                cordic_valid_strobe_o,
    input  logic [N_FRAC:0]     cordic_x_i,
    input  logic [N_FRAC:0]     cordic_y_i,
    input  logic                cordic_valid_strobe_i,
    output logic [N_FRAC:0]     cos_o,
    output logic [N_FRAC:0]     sin_o,
    output logic                sample_valid_strobe_o,
    output logic                busy_o,
    output logic                overrun_o
);
    localparam int W = N_FRAC + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} state_t;

    state_t              state, state_n;
    logic [BW_PHASE-1:0] phase_acc;
    logic [N_FRAC:0]     z_raw;
    logic                fold, fold_n, accept;

    function automatic logic [N_FRAC:0] neg_sat(input logic [N_FRAC:0] v);
        return (v == {1'b1, {N_FRAC{1'b0}}}) ? {1'b0, {N_FRAC{1'b1}}} : -v;
    endfunction

    assign z_raw                 = phase_acc[BW_PHASE-1 -: W];
    assign fold_n                = z_raw[N_FRAC] ^ z_raw[N_FRAC-1];
    assign accept                = state == IDLE && sample_strobe_i && enable_i;
    assign cordic_valid_strobe_o = state == ISSUE;
    assign sample_valid_strobe_o = state == OUTPUT;
    assign busy_o                = state != IDLE;

    // state register
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= IDLE;
        else       state <= state_n;

    // next state: one pass IDLE -> ISSUE -> WAIT (until result) -> OUTPUT -> IDLE
    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:    state_n = accept ? ISSUE : IDLE;
            ISSUE:   state_n = WAIT;
            WAIT:    state_n = cordic_valid_strobe_i ? OUTPUT : WAIT;
            default: state_n = IDLE;
        endcase
    end

    // operands, phase accumulation, unfolded result capture and sticky overrun
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            phase_acc  <= '0;
            cordic_x_o <= '0;
            cordic_y_o <= '0;
            cordic_z_o <= '0;
            fold       <= 1'b0;
            cos_o      <= '0;
            sin_o      <= '0;
            overrun_o  <= 1'b0;
        end else begin
            if (accept) begin
                cordic_z_o <= fold_n ? {~z_raw[N_FRAC], z_raw[N_FRAC-1:0]} : z_raw;
                cordic_x_o <= W'(X_INIT);
                cordic_y_o <= '0;
                fold       <= fold_n;
            end
            if (state == ISSUE) phase_acc <= phase_acc + phase_inc_i;
            if (state == WAIT && cordic_valid_strobe_i) begin
                cos_o <= fold ? neg_sat(cordic_x_i) : cordic_x_i;
                sin_o <= fold ? neg_sat(cordic_y_i) : cordic_y_i;
            end
            if (sample_strobe_i && state != IDLE) overrun_o <= 1'b1;
        end
endmodule

// File: tb/tb_cordic_phase_sequencer.sv
// tb_cordic_phase_sequencer: randomized and directed check against a transaction-level reference model
module tb_cordic_phase_sequencer;
    logic        clk = 0, rst_i = 1, enable_i = 0, sample_strobe_i = 0;
    logic [15:0] phase_inc_i = '0;
    logic [7:0]  cordic_x_o, cordic_y_o, cordic_z_o, cos_o, sin_o;
    logic [7:0]  cordic_x_i = '0, cordic_y_i = '0;
    logic        cordic_valid_strobe_o, cordic_valid_strobe_i = 0;
    logic        sample_valid_strobe_o, busy_o, overrun_o;

    int n_chk = 0, n_fail = 0;

    cordic_phase_sequencer dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .phase_inc_i(phase_inc_i),
        .sample_strobe_i(sample_strobe_i),
        .cordic_x_o(cordic_x_o), .cordic_y_o(cordic_y_o), .cordic_z_o(cordic_z_o),
        .cordic_valid_strobe_o(cordic_valid_strobe_o),
        .cordic_x_i(cordic_x_i), .cordic_y_i(cordic_y_i), .cordic_valid_strobe_i(cordic_valid_strobe_i),
        .cos_o(cos_o), .sin_o(sin_o), .sample_valid_strobe_o(sample_valid_strobe_o),
        .busy_o(busy_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int sat_neg(input int v);
        return v == -128 ? 127 : -v;
    endfunction

    function automatic int rnd(input real v);
        return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
    endfunction

    // reference model: one transaction at a time, tracked by the cycle numbers of its events
    int          cyc = 0, t_acc = 0, t_res = 0, tmp_a;
    int          m_x = 0, m_y = 0, m_z = 0, m_cos = 0, m_sin = 0;
    int unsigned m_phase = 0;
    bit          inflight = 0, have_res = 0, m_fold = 0, m_ovr = 0, run_cmp = 0;

    always @(negedge clk) begin
        if (rst_i) begin
            inflight = 0; have_res = 0; m_ovr = 0; m_phase = 0; m_fold = 0;
            m_x = 0; m_y = 0; m_z = 0; m_cos = 0; m_sin = 0;
        end
        if (run_cmp) begin
            chk("busy", busy_o, inflight);
            chk("cordic_valid", cordic_valid_strobe_o, inflight && cyc == t_acc + 1);
            chk("sample_valid", sample_valid_strobe_o, inflight && have_res && cyc == t_res + 1);
            chk("overrun", overrun_o, m_ovr);
            chk("cos", $signed(cos_o), m_cos);
            chk("sin", $signed(sin_o), m_sin);
            chk("cordic_x", $signed(cordic_x_o), m_x);
            chk("cordic_y", $signed(cordic_y_o), m_y);
            chk("cordic_z", $signed(cordic_z_o), m_z);
        end
        if (inflight) begin
            if (sample_strobe_i) m_ovr = 1;
            if (cyc == t_acc + 1) m_phase = (m_phase + phase_inc_i) % 65536;
            if (!have_res && cyc >= t_acc + 2 && cordic_valid_strobe_i) begin
                have_res = 1; t_res = cyc;
                m_cos = m_fold ? sat_neg($signed(cordic_x_i)) : $signed(cordic_x_i);
                m_sin = m_fold ? sat_neg($signed(cordic_y_i)) : $signed(cordic_y_i);
            end else if (have_res && cyc == t_res + 1) inflight = 0;
        end else if (sample_strobe_i && enable_i) begin
            tmp_a = int'(m_phase >> 8);
            if (tmp_a > 127) tmp_a -= 256;
            m_fold = tmp_a >= 64 || tmp_a <= -65;
            m_z = tmp_a >= 64 ? tmp_a - 128 : tmp_a <= -65 ? tmp_a + 128 : tmp_a;
            m_x = 77; m_y = 0;
            inflight = 1; have_res = 0; t_acc = cyc;
        end
        cyc++;
    end

    // CORDIC stand-in: answers each issue after a latency, optionally forced or random data
    bit rnd_mode = 0, pend = 0, force_set = 0;
    int fire = 0, rz = 0, force_v = 0;

    always @(posedge clk) begin
        #1;
        cordic_valid_strobe_i = 0;
        if (cordic_valid_strobe_o) begin
            pend = 1; rz = $signed(cordic_z_o);
            fire = cyc + (rnd_mode ? int'($urandom_range(1, 12)) : 6);
        end else if (pend && cyc >= fire) begin
            pend = 0; cordic_valid_strobe_i = 1;
            cordic_x_i = 8'(rnd(126.0 * $cos(real'(rz) * 3.141592653589793 / 128.0)));
            cordic_y_i = 8'(rnd(126.0 * $sin(real'(rz) * 3.141592653589793 / 128.0)));
            if (force_set) begin
                cordic_x_i = 8'(force_v); force_set = 0;
            end else if (rnd_mode && $urandom_range(0, 1) == 1) begin
                cordic_x_i = 8'($urandom); cordic_y_i = 8'($urandom);
            end
        end else if (rnd_mode && $urandom_range(0, 15) == 0) begin
            cordic_valid_strobe_i = 1; cordic_x_i = 8'($urandom); cordic_y_i = 8'($urandom);
        end
    end

    task automatic wait_sample(output bit seen);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick;
            seen = sample_valid_strobe_o;
        end
        chk("sample_done", seen, 1);
    endtask

    task automatic do_sample(input logic [15:0] inc);
        bit seen;
        tick; enable_i = 1; phase_inc_i = inc; sample_strobe_i = 1;
        tick; sample_strobe_i = 0;
        wait_sample(seen);
    endtask

    initial begin
        bit seen;
        int svs_cnt;
        repeat (3) tick;
        rst_i = 0; run_cmp = 1;
        chk("rst_busy", busy_o, 0);
        chk("rst_cos", $signed(cos_o), 0);

        do_sample(16'h0800);
        chk("s1_z", $signed(cordic_z_o), 0);
        chk("s1_x", $signed(cordic_x_o), 77);
        chk("s1_y", $signed(cordic_y_o), 0);
        chk("s1_cos", $signed(cos_o), 126);
        chk("s1_sin", $signed(sin_o), 0);
        chk("s1_phase", m_phase, 32'h0800);

        do_sample(16'h7800);
        chk("s2_z", $signed(cordic_z_o), 8);

        do_sample(16'hC000);
        chk("s3_z", $signed(cordic_z_o), 0);
        chk("s3_cos", $signed(cos_o), -126);
        chk("s3_sin", $signed(sin_o), 0);

        do_sample(16'h0000);
        chk("s4_z", $signed(cordic_z_o), -64);
        chk("s4_sin", $signed(sin_o), 126);
        chk("s4_cos", $signed(cos_o), 0);

        force_set = 1; force_v = -128;
        do_sample(16'h0000);
        chk("sat_cos", $signed(cos_o), 127);

        tick; sample_strobe_i = 1;
        tick; sample_strobe_i = 0;
        tick; tick; sample_strobe_i = 1;
        tick; sample_strobe_i = 0;
        wait_sample(seen);
        chk("overrun_set", overrun_o, 1);
        repeat (5) tick;
        chk("overrun_sticky", overrun_o, 1);

        tick; sample_strobe_i = 1;
        tick; sample_strobe_i = 0;
        tick; tick;
        #1 rst_i = 1;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_cvs", cordic_valid_strobe_o, 0);
        chk("arst_x", $signed(cordic_x_o), 0);
        chk("arst_z", $signed(cordic_z_o), 0);
        chk("arst_cos", $signed(cos_o), 0);
        chk("arst_sin", $signed(sin_o), 0);
        chk("arst_ovr", overrun_o, 0);
        @(negedge clk); #1 rst_i = 0;
        svs_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick;
            svs_cnt += int'(sample_valid_strobe_o);
        end
        chk("late_result_dropped", svs_cnt, 0);
        chk("late_cos", $signed(cos_o), 0);
        chk("late_sin", $signed(sin_o), 0);

        rnd_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            tick;
            sample_strobe_i = $urandom_range(0, 3) == 0;
            enable_i = $urandom_range(0, 4) != 0;
            phase_inc_i = 16'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #1 rst_i = 1;
                @(negedge clk); #1 rst_i = 0;
            end
        end
        sample_strobe_i = 0; enable_i = 0;
        repeat (30) tick;
        chk("drain_idle", busy_o, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
